// File: rtl/length_packing_unit.sv
// Packs left-aligned variable-length code chunks MSB-first into a staging buffer
// and emits fixed-width output blocks. A flush request drains the residue as a zero-padded block.
//
//   state | meaning
//   RUN   | accepting chunks, emitting full blocks
//   FLUSH | input closed; full blocks then one padded block drain out, then back to RUN
module length_packing_unit #(
  parameter int WIDTH     = 64,
  parameter int OUT_WIDTH = 128
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_valid,
  input  logic [WIDTH-1:0]     i_code,
  input  logic [6:0]           i_total_length,
  input  logic                 i_flush,
  output logic                 o_ready,
  output logic [OUT_WIDTH-1:0] o_block,
  output logic                 o_block_valid,
  output logic [7:0]           o_block_bits,
  input  logic                 i_out_ready,
  output logic [7:0]           o_fill_count,
  output logic                 o_flush_done
);

  localparam int BUF_WIDTH = OUT_WIDTH + WIDTH;
  localparam logic [7:0] OUT_BITS = 8'(OUT_WIDTH);
  localparam logic [6:0] MAX_LEN  = 7'(WIDTH);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t               state;
  logic [BUF_WIDTH-1:0] buffer;
  logic [7:0]           count;

  logic                 out_fire, slot_free, pop, pad_pop, accept;
  logic [6:0]           len;
  logic [WIDTH-1:0]     code_masked;
  logic [7:0]           count_after_pop, count_next;
  logic [BUF_WIDTH-1:0] buf_after_pop, buf_next;
  logic [OUT_WIDTH-1:0] block_head, block_padded;

  always_comb begin
    out_fire        = o_block_valid && i_out_ready;
    slot_free       = !o_block_valid || out_fire;
    pop             = slot_free && (count >= OUT_BITS);
    pad_pop         = (state == FLUSH) && slot_free && (count != 8'd0) && (count < OUT_BITS);
    o_ready         = !i_reset && (state == RUN) && (count <= OUT_BITS);
    accept          = i_valid && o_ready;
    len             = (i_total_length > MAX_LEN) ? MAX_LEN : i_total_length;
    code_masked     = i_code & ~({WIDTH{1'b1}} >> len);
    block_head      = buffer[BUF_WIDTH-1 -: OUT_WIDTH];
    // Residue bits are already zero below count; the mask makes the padding explicit.
    block_padded    = block_head & ~({OUT_WIDTH{1'b1}} >> count);
    count_after_pop = count;
    buf_after_pop   = buffer;
    if (pop) begin
      count_after_pop = count - OUT_BITS;
      buf_after_pop   = buffer << OUT_WIDTH;
    end else if (pad_pop) begin
      count_after_pop = 8'd0;
      buf_after_pop   = '0;
    end
    count_next = count_after_pop;
    buf_next   = buf_after_pop;
    if (accept) begin
      // count_after_pop <= OUT_WIDTH here, so the chunk always lands inside the buffer.
      buf_next   = buf_after_pop | ({code_masked, {OUT_WIDTH{1'b0}}} >> count_after_pop);
      count_next = count_after_pop + {1'b0, len};
    end
    o_fill_count = count;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state         <= RUN;
      buffer        <= '0;
      count         <= '0;
      o_block       <= '0;
      o_block_valid <= 1'b0;
      o_block_bits  <= '0;
      o_flush_done  <= 1'b0;
    end else begin
      buffer       <= buf_next;
      count        <= count_next;
      o_flush_done <= 1'b0;
      if (pop || pad_pop) begin
        o_block       <= pop ? block_head : block_padded;
        o_block_bits  <= pop ? OUT_BITS : count;
        o_block_valid <= 1'b1;
      end else if (out_fire) begin
        o_block_valid <= 1'b0;
      end
      case (state)
        RUN: begin
          if (i_flush) state <= FLUSH;
        end
        FLUSH: begin
          if (count == 8'd0) begin
            state        <= RUN;
            o_flush_done <= 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_length_packing_unit.sv
// Directed bench for length_packing_unit: hand-computed blocks, counts and flush pulses.
module tb_length_packing_unit;

  logic         i_clk = 1'b0;
  logic         i_reset, i_valid, i_flush, i_out_ready;
  logic [63:0]  i_code;
  logic [6:0]   i_total_length;
  logic         o_ready, o_block_valid, o_flush_done;
  logic [127:0] o_block;
  logic [7:0]   o_block_bits, o_fill_count;

  int checks   = 0;
  int failures = 0;

  length_packing_unit dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .i_code(i_code),
    .i_total_length(i_total_length), .i_flush(i_flush), .o_ready(o_ready),
    .o_block(o_block), .o_block_valid(o_block_valid), .o_block_bits(o_block_bits),
    .i_out_ready(i_out_ready), .o_fill_count(o_fill_count), .o_flush_done(o_flush_done)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  logic [63:0]  a, b, c, d;
  logic [47:0]  x, y, z;
  logic [143:0] stream;
  logic [63:0]  ch [6];
  logic [127:0] got [4];
  int           idx, nb;
  logic         acc;

  initial begin
    a = 64'h0123_4567_89AB_CDEF;
    b = 64'hFEDC_BA98_7654_3210;
    c = 64'h1357_9BDF_0246_8ACE;
    d = 64'hC0FF_EE00_DEAD_BEEF;
    x = 48'h1111_2222_3333;
    y = 48'h4444_5555_6666;
    z = 48'h7777_8888_9999;
    stream = {x, y, z};
    for (int i = 0; i < 6; i++) ch[i] = {8'(i + 1), 56'hA5_0000_0000_005A} ^ {32'(i * 7), 32'hF0F0_0000};

    i_reset = 1'b1; i_valid = 1'b0; i_flush = 1'b0; i_out_ready = 1'b0;
    i_code = '0; i_total_length = '0;
    tick();
    check("rst_ready", o_ready, 0);
    check("rst_valid", o_block_valid, 0);
    check("rst_count", o_fill_count, 0);
    check("rst_block", o_block, 0);
    i_reset = 1'b0;
    tick();

    // two full chunks form one block
    i_out_ready = 1'b1;
    i_valid = 1'b1; i_code = a; i_total_length = 7'd64;
    tick();
    i_code = b;
    tick();
    i_valid = 1'b0;
    tick();
    check("ab_block", o_block, {a, b});
    check("ab_bits", o_block_bits, 128);
    check("ab_valid", o_block_valid, 1);
    check("ab_count", o_fill_count, 0);
    tick();
    check("ab_valid_drop", o_block_valid, 0);

    // three 48-bit chunks (garbage in unused low bits), then flush
    i_valid = 1'b1; i_total_length = 7'd48;
    i_code = {x, 16'hFFFF}; tick();
    i_code = {y, 16'hFFFF}; tick();
    i_code = {z, 16'hFFFF}; tick();
    i_valid = 1'b0; i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    check("f48_block1", o_block, stream[143:16]);
    check("f48_bits1", o_block_bits, 128);
    check("f48_count1", o_fill_count, 16);
    tick();
    check("f48_block2", o_block, {stream[15:0], 112'b0});
    check("f48_bits2", o_block_bits, 16);
    check("f48_count2", o_fill_count, 0);
    check("f48_done_early", o_flush_done, 0);
    tick();
    check("f48_done", o_flush_done, 1);
    tick();
    check("f48_done_once", o_flush_done, 0);

    // backpressure: five chunks fill the buffer
    i_out_ready = 1'b0;
    idx = 0;
    for (int k = 0; k < 20 && idx < 5; k++) begin
      i_valid = 1'b1; i_code = ch[idx]; i_total_length = 7'd64;
      acc = o_ready;
      tick();
      if (acc) idx++;
    end
    i_valid = 1'b0;
    check("bp_accepted", idx, 5);
    check("bp_count", o_fill_count, 192);
    check("bp_ready", o_ready, 0);
    check("bp_valid", o_block_valid, 1);
    // release backpressure and offer a sixth chunk
    i_out_ready = 1'b1;
    i_valid = 1'b1; i_code = ch[5];
    nb = 0;
    for (int k = 0; k < 8; k++) begin
      if (o_block_valid) begin
        if (nb < 4) got[nb] = o_block;
        nb++;
      end
      acc = i_valid && o_ready;
      tick();
      if (acc) i_valid = 1'b0;
    end
    i_valid = 1'b0;
    check("bp_nblocks", nb, 3);
    check("bp_blk0", got[0], {ch[0], ch[1]});
    check("bp_blk1", got[1], {ch[2], ch[3]});
    check("bp_blk2", got[2], {ch[4], ch[5]});
    check("bp_count_end", o_fill_count, 0);

    // reset mid-stream with count=96 and a block pending
    i_out_ready = 1'b0;
    i_valid = 1'b1; i_total_length = 7'd64;
    i_code = a; tick();
    i_code = b; tick();
    i_code = c; tick();
    i_code = d; i_total_length = 7'd32; tick();
    i_valid = 1'b0;
    check("mid_count", o_fill_count, 96);
    check("mid_valid", o_block_valid, 1);
    i_reset = 1'b1;
    tick();
    check("mid_rst_valid", o_block_valid, 0);
    check("mid_rst_count", o_fill_count, 0);
    check("mid_rst_block", o_block, 0);
    check("mid_rst_bits", o_block_bits, 0);
    check("mid_rst_ready", o_ready, 0);
    i_reset = 1'b0;
    tick();
    check("mid_ready", o_ready, 1);
    i_out_ready = 1'b1;

    // zero length and clamped length
    i_valid = 1'b1;
    i_code = {32'hABCD_EF01, 32'hFFFF_FFFF}; i_total_length = 7'd32; tick();
    i_code = 64'hFFFF_FFFF_FFFF_FFFF; i_total_length = 7'd0; tick();
    check("len0_count", o_fill_count, 32);
    i_code = 64'h5555_AAAA_1234_5678; i_total_length = 7'd100; tick();
    check("len100_count", o_fill_count, 96);
    i_code = {32'h9ABC_DEF0, 32'hDEAD_BEEF}; i_total_length = 7'd32; tick();
    check("len_count128", o_fill_count, 128);
    i_valid = 1'b0;
    tick();
    check("len_block", o_block, {32'hABCD_EF01, 64'h5555_AAAA_1234_5678, 32'h9ABC_DEF0});
    check("len_count0", o_fill_count, 0);
    tick();

    // flush with empty buffer
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    check("fe_ready", o_ready, 0);
    check("fe_done_early", o_flush_done, 0);
    check("fe_valid", o_block_valid, 0);
    tick();
    check("fe_done", o_flush_done, 1);
    check("fe_noblock", o_block_valid, 0);
    tick();
    check("fe_done_once", o_flush_done, 0);

    // flush together with an accepted chunk
    i_valid = 1'b1; i_flush = 1'b1;
    i_code = {40'h12_3456_789A, 24'hFF_FFFF}; i_total_length = 7'd40;
    tick();
    i_valid = 1'b0; i_flush = 1'b0;
    check("fc_count", o_fill_count, 40);
    check("fc_ready", o_ready, 0);
    tick();
    check("fc_block", o_block, {40'h12_3456_789A, 88'b0});
    check("fc_bits", o_block_bits, 40);
    check("fc_valid", o_block_valid, 1);
    tick();
    check("fc_done", o_flush_done, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/length_packing_unit.md
# length_packing_unit

Packing stage of the compression datapath, directly downstream of the length/packing pipeline register. Each cycle it accepts one left-aligned chunk of compressed bits (0–64 valid bits) and appends it MSB-first into a 192-bit staging buffer. It emits fixed 128-bit output blocks over a valid/ready handshake. On request it flushes the residual bits as a zero-padded final block.

## Interface
- WIDTH, 64, input chunk width; the design is specified for 64.
- OUT_WIDTH, 128, output block width; the design is specified for 128.
- BUF_WIDTH, 192, staging buffer width; fixed at OUT_WIDTH + WIDTH.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  reset, synchronous, active-high.
- i_valid  in  1  input chunk valid.
- i_code  in  WIDTH  compressed bits, left-aligned; bit [WIDTH-1] is first.
- i_total_length  in  7  number of valid bits in i_code, 0..64.
- i_flush  in  1  request to drain and pad the residual bits.
- o_ready  out  1  chunk accepted when i_valid && o_ready.
- o_block  out  OUT_WIDTH  output block; bit [127] is first.
- o_block_valid  out  1  o_block holds an unconsumed block.
- o_block_bits  out  8  meaningful bits in o_block: 128, or 1..127 for a padded final block.
- i_out_ready  in  1  downstream accepts o_block.
- o_fill_count  out  8  bits currently held in the staging buffer, 0..192.
- o_flush_done  out  1  one-cycle pulse when a flush completes.

## Operation
Reset:
- i_reset is sampled at a clock edge.
- Reset clears buffer, count, o_block, o_block_valid, o_block_bits, o_flush_done and state (state=RUN).
- o_ready=0 while i_reset=1.

States:
- RUN:
  - o_ready = (count <= 128).
  - Go to FLUSH when i_flush=1.
- FLUSH:
  - o_ready=0; i_valid is ignored.
  - Go to RUN when count==0 and no padded emission is pending; o_flush_done pulses on that transition cycle.

Per-cycle order:
- out_fire = o_block_valid && i_out_ready.
- slot_free = !o_block_valid || out_fire.

Pop:
- Occurs if slot_free and count >= 128.
- o_block <= buf[191:64], o_block_bits <= 128, count -= 128, buffer shifted left 128.

Padded pop:
- Occurs in FLUSH only, if slot_free and 0 < count < 128.
- o_block <= buf[191:64] with bits below position 128-count forced to 0.
- o_block_bits <= count, count <= 0.

Valid update:
- o_block_valid <= 1 on any pop.
- Otherwise o_block_valid <= 0 on out_fire, else it holds.

Append:
- Occurs if i_valid && o_ready.
- len = min(i_total_length, 64); values >64 are clamped to 64.
- Masked i_code[63:64-len] is written at buffer position count_after_pop (MSB-first).
- count <= count_after_pop + len.
- len=0 is accepted and changes nothing.

Flush entry:
- i_flush in RUN in the same cycle as an accepted chunk: the chunk is appended first, then FLUSH is entered.
- i_flush while already in FLUSH is ignored.

Invariants:
- count <= 192 at all times.
- No bit is dropped or duplicated.
- Bits appear in o_block in exactly arrival order.

## Timing
- Chunk accepted at edge N that brings count >= 128 with the slot free: o_block_valid=1 after edge N+1. Latency 2 cycles from i_valid to o_block_valid.
- o_block is stable while o_block_valid && !i_out_ready.
- Back-to-back blocks:
  - With i_out_ready=1 continuously, a new block can load on the same edge as the previous one is consumed.
  - Sustained throughput is 64 bits/cycle.
- Flush with count==0 and slot free: o_flush_done pulses the cycle after i_flush.
- Flush with residual r < 128:
  - Padded block loads 1 cycle after FLUSH entry, once the slot is free.
  - o_flush_done pulses the following cycle.
- o_ready is combinational from registered state/count; it never depends on i_valid.

## Test plan
- Reset: assert i_reset mid-stream with count=96 and o_block_valid=1 -> next cycle all outputs 0, o_fill_count=0, state RUN.
- Two 64-bit chunks A, B with i_out_ready=1 -> o_block={A,B}, o_block_bits=128, one cycle valid, count=0.
- Three 48-bit chunks then i_flush:
  - First result: first block is 128 bits, count=16.
  - Second result: next block is the last 16 bits followed by 112 zero bits, o_block_bits=16.
  - Third result: o_flush_done pulses once.
- Backpressure with i_out_ready=0 and 64-bit chunks each cycle:
  - Five chunks are accepted; count=192 and o_ready=0.
  - Raising i_out_ready then yields two blocks followed by a third, in exact input order; no loss.
- i_total_length=0 -> count unchanged. i_total_length=100 -> clamped to 64 bits appended.
- i_flush with count==0 -> no block emitted, o_flush_done one cycle later. i_flush with a simultaneous accepted chunk -> chunk included in the padded block.
